// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: hazard scheduler beside the ID/EX pipeline register.
// Shadows Rd/RegWrite/MemtoReg/SetFlag of the instructions in EX and MEM,
// and produces stall, IF/ID flush, a bubbled control word and registered
// EX-stage forwarding selects.
// Optional feature macro: HAZ_FORWARD_EN (defined = forwarding enabled;
// undefined = forwarding selects tied to 00 and every RAW dependency stalls).
module id_ex_hazard_ctrl #(
   parameter int CTRL_W       = 10,
   parameter int RW_BIT       = 0,
   parameter int MTR_BIT      = 2,
   parameter int MW_BIT       = 3,
   parameter int SF_BIT       = 4,
   parameter int FLUSH_CYCLES = 1,
   parameter int ZR           = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        Rn_id,
   input  logic [4:0]        Rm_id,
   input  logic              useA_id,
   input  logic              useB_id,
   input  logic              flag_use_id,
   input  logic [4:0]        Rd_id,
   input  logic [CTRL_W-1:0] control_id,
   input  logic              branch_taken,
   output logic              stall,
   output logic              flush_ifid,
   output logic [CTRL_W-1:0] ctrl_ex_in,
   output logic [1:0]        fwdA_ex,
   output logic [1:0]        fwdB_ex,
   output logic [1:0]        busy_state
);

   localparam logic [1:0] ST_RUN   = 2'b00;
   localparam logic [1:0] ST_STALL = 2'b01;
   localparam logic [1:0] ST_FLUSH = 2'b10;
   localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

   logic [1:0] state;
   logic [1:0] cnt;

   logic [4:0] rd_ex, rd_mem;
   logic       rw_ex, rw_mem;
   logic       sf_ex;

   logic match_ex_a, match_ex_b, match_mem_a, match_mem_b;
   logic flag_haz, raw_haz, bubble;

   // A source hits a shadow entry only if it is read, matches a live write and is not ZR.
   function automatic logic hit(input logic use_s, input logic [4:0] s,
                                input logic [4:0] rd, input logic rw);
      return use_s && (s == rd) && rw && (s != 5'(ZR));
   endfunction

`ifdef HAZ_FORWARD_EN
   logic mtr_ex;
   logic load_use;
   logic unused_mw;
   // MemWrite plays no part in hazard detection; a bubble clears it with the rest.
   assign unused_mw = control_id[MW_BIT];
`else
   logic sf_mem;
   logic [1:0] unused_bits;
   // Without forwarding the producer type is irrelevant: every RAW stalls.
   assign unused_bits = {control_id[MTR_BIT], control_id[MW_BIT]};
`endif

   // Hazard detection and combinational stall/flush/bubble outputs.
   always_comb begin
      match_ex_a  = hit(useA_id, Rn_id, rd_ex, rw_ex);
      match_ex_b  = hit(useB_id, Rm_id, rd_ex, rw_ex);
      match_mem_a = hit(useA_id, Rn_id, rd_mem, rw_mem);
      match_mem_b = hit(useB_id, Rm_id, rd_mem, rw_mem);
      flag_haz    = flag_use_id & sf_ex;
`ifdef HAZ_FORWARD_EN
      load_use    = (match_ex_a | match_ex_b) & mtr_ex;
      raw_haz     = load_use | flag_haz;
`else
      raw_haz     = match_ex_a | match_ex_b | match_mem_a | match_mem_b |
                    flag_haz | (flag_use_id & sf_mem);
`endif
      stall       = raw_haz & ~branch_taken & (state != ST_FLUSH);
      flush_ifid  = branch_taken | (state == ST_FLUSH);
      bubble      = stall | flush_ifid;
      ctrl_ex_in  = bubble ? '0 : control_id;
   end

   assign busy_state = state;

   // Shadow of the EX and MEM stages; bubbles enter with RegWrite/SetFlag clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ex  <= '0;
         rw_ex  <= 1'b0;
         sf_ex  <= 1'b0;
         rd_mem <= '0;
         rw_mem <= 1'b0;
`ifdef HAZ_FORWARD_EN
         mtr_ex <= 1'b0;
`else
         sf_mem <= 1'b0;
`endif
      end else begin
         rd_ex  <= Rd_id;
         rw_ex  <= ctrl_ex_in[RW_BIT];
         sf_ex  <= ctrl_ex_in[SF_BIT];
         rd_mem <= rd_ex;
         rw_mem <= rw_ex;
`ifdef HAZ_FORWARD_EN
         mtr_ex <= ctrl_ex_in[MTR_BIT];
`else
         sf_mem <= sf_ex;
`endif
      end
   end

   // Scheduler FSM: branch redirect beats RAW stall; FLUSH dwells FLUSH_CYCLES slots.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (branch_taken) begin
                  state <= ST_FLUSH;
                  cnt   <= CNT_LOAD;
               end else if (raw_haz) begin
                  state <= ST_STALL;
               end
            end
            ST_STALL: begin
               if (branch_taken) begin
                  state <= ST_FLUSH;
                  cnt   <= CNT_LOAD;
               end else if (!raw_haz) begin
                  state <= ST_RUN;
               end
            end
            ST_FLUSH: begin
               if (branch_taken) begin
                  cnt <= CNT_LOAD;
               end else if (cnt == 2'd0) begin
                  state <= ST_RUN;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            default: begin
               state <= ST_RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef HAZ_FORWARD_EN
   // Forwarding selects for the instruction entering EX; EX/MEM result beats MEM/WB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwdA_ex <= 2'b00;
         fwdB_ex <= 2'b00;
      end else if (bubble) begin
         fwdA_ex <= 2'b00;
         fwdB_ex <= 2'b00;
      end else begin
         fwdA_ex <= (match_ex_a & ~mtr_ex) ? 2'b01 : match_mem_a ? 2'b10 : 2'b00;
         fwdB_ex <= (match_ex_b & ~mtr_ex) ? 2'b01 : match_mem_b ? 2'b10 : 2'b00;
      end
   end
`else
   assign fwdA_ex = 2'b00;
   assign fwdB_ex = 2'b00;
`endif

endmodule
